pool_fc_packer: RTL and testbench

POOL_FC_PACKER -- requirements
Module: pool_fc_packer

---
 rtl/pool_fc_packer.sv | 108 ++++++++++
 tb/tb_pool_fc_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_fc_packer.sv
// Packs a stream of pooled pixel bytes into LANES-wide words for the FC stage.
// Tracks words per frame and flags a sticky error when the count differs from EXP_WORDS.
module pool_fc_packer #(
    parameter int LANES     = 12,
    parameter int EXP_WORDS = 96
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [7:0]         i_px_data,
    input  logic               i_px_valid,
    input  logic               i_px_last,
    output logic [8*LANES-1:0] o_pool_data,
    output logic               o_pool_valid,
    output logic               o_pool_end,
    output logic               o_busy,
    output logic               o_err
);
    localparam int            LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [15:0]   EXP_CNT   = 16'(EXP_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_END
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LW-1:0]      lane_cnt;
    logic [8*LANES-1:0] lane_buf;
    logic [8*LANES-1:0] word_nxt;
    logic [15:0]        word_cnt;
    logic               take;
    logic               emit;

    // Start always wins over a byte arriving in the same cycle.
    assign take   = (state == ST_COLLECT) && !i_start && i_px_valid;
    assign emit   = take && ((lane_cnt == LAST_LANE) || i_px_last);
    assign o_busy = (state == ST_COLLECT) || (state == ST_END);

    // The partially filled buffer with the incoming byte merged into its lane;
    // lanes not yet written stay zero because the buffer clears on every emit.
    always_comb begin
        word_nxt = lane_buf;
        word_nxt[8*lane_cnt +: 8] = i_px_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (i_start) state_nxt = ST_COLLECT;
            ST_COLLECT: if (take && i_px_last) state_nxt = ST_END;
            ST_END:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // END ignores every input; otherwise a start clears the frame, including an
    // in-progress one, before any byte is considered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane_cnt     <= '0;
            lane_buf     <= '0;
            word_cnt     <= '0;
            o_pool_data  <= '0;
            o_pool_valid <= 1'b0;
            o_pool_end   <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_pool_valid <= 1'b0;
            o_pool_end   <= 1'b0;
            if (state == ST_END) begin
                o_pool_end <= 1'b1;
                if (word_cnt != EXP_CNT) begin
                    o_err <= 1'b1;
                end
            end else if (i_start) begin
                lane_cnt <= '0;
                lane_buf <= '0;
                word_cnt <= '0;
                o_err    <= 1'b0;
            end else if (take) begin
                if (emit) begin
                    o_pool_data  <= word_nxt;
                    o_pool_valid <= 1'b1;
                    lane_buf     <= '0;
                    lane_cnt     <= '0;
                    if (word_cnt != 16'hFFFF) begin
                        word_cnt <= word_cnt + 16'd1;
                    end
                end else begin
                    lane_buf <= word_nxt;
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_fc_packer.sv
// Checks two packer instances (EXP_WORDS 96 and 2) fed the same stream against a
// byte-queue reference model, plus literal expectations for known frames.
module tb_pool_fc_packer;
    localparam int LANES = 12;
    localparam int EXP_A = 96;
    localparam int EXP_B = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              i_start = 1'b0;
    logic [7:0]        i_px_data = '0;
    logic              i_px_valid = 1'b0;
    logic              i_px_last = 1'b0;
    logic [8*LANES-1:0] data_a, data_b;
    logic              valid_a, valid_b, end_a, end_b, busy_a, busy_b, err_a, err_b;

    int total = 0;
    int bad = 0;

    pool_fc_packer #(.LANES(LANES), .EXP_WORDS(EXP_A)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_px_data(i_px_data),
        .i_px_valid(i_px_valid), .i_px_last(i_px_last), .o_pool_data(data_a),
        .o_pool_valid(valid_a), .o_pool_end(end_a), .o_busy(busy_a), .o_err(err_a)
    );

    pool_fc_packer #(.LANES(LANES), .EXP_WORDS(EXP_B)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_px_data(i_px_data),
        .i_px_valid(i_px_valid), .i_px_last(i_px_last), .o_pool_data(data_b),
        .o_pool_valid(valid_b), .o_pool_end(end_b), .o_busy(busy_b), .o_err(err_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [95:0] actual, input logic [95:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: bytes gather in a queue; a word is the queue packed
    // lane 0 first, emitted when full or on the last byte.
    logic [95:0]  m_data = '0;
    logic         m_valid = 1'b0, m_end = 1'b0, m_err_a = 1'b0, m_err_b = 1'b0;
    bit           m_active = 1'b0, m_ending = 1'b0;
    byte unsigned m_bytes[$];
    int           m_words = 0;

    function automatic logic [95:0] pack_word(input byte unsigned b[$]);
        logic [95:0] w;
        w = '0;
        foreach (b[k]) w[8*k +: 8] = b[k];
        return w;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_data = '0; m_valid = 0; m_end = 0; m_err_a = 0; m_err_b = 0;
            m_active = 0; m_ending = 0; m_words = 0;
            m_bytes.delete();
        end else begin
            m_valid = 0;
            m_end = 0;
            if (m_ending) begin
                m_ending = 0;
                m_end = 1;
                if (m_words != EXP_A) m_err_a = 1;
                if (m_words != EXP_B) m_err_b = 1;
            end else if (i_start) begin
                m_active = 1;
                m_words = 0;
                m_err_a = 0;
                m_err_b = 0;
                m_bytes.delete();
            end else if (m_active && i_px_valid) begin
                m_bytes.push_back(i_px_data);
                if (m_bytes.size() == LANES || i_px_last) begin
                    m_data = pack_word(m_bytes);
                    m_valid = 1;
                    m_bytes.delete();
                    if (m_words < 65535) m_words++;
                    if (i_px_last) begin
                        m_active = 0;
                        m_ending = 1;
                    end
                end
            end
        end
    end

    always @(negedge i_clk) begin
        check_output("a_valid", 96'(valid_a), 96'(m_valid));
        check_output("a_data", data_a, m_data);
        check_output("a_end", 96'(end_a), 96'(m_end));
        check_output("a_busy", 96'(busy_a), 96'(m_active || m_ending));
        check_output("a_err", 96'(err_a), 96'(m_err_a));
        check_output("b_valid", 96'(valid_b), 96'(m_valid));
        check_output("b_data", data_b, m_data);
        check_output("b_end", 96'(end_b), 96'(m_end));
        check_output("b_busy", 96'(busy_b), 96'(m_active || m_ending));
        check_output("b_err", 96'(err_b), 96'(m_err_b));
    end

    logic [95:0] words_a[$];
    logic [95:0] words_b[$];
    logic [95:0] ref_words[$];

    always @(negedge i_clk) begin
        if (valid_a) words_a.push_back(data_a);
        if (valid_b) words_b.push_back(data_b);
    end

    task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic l);
        i_start = s;
        i_px_valid = v;
        i_px_data = d;
        i_px_last = l;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    // Start (with a colliding byte that must be dropped), then n bytes.
    // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..2 idles.
    task automatic apply_stimulus(input int n, input int base, input bit rnd,
                                  input int gap_mode, input bit with_last);
        drive(1'b1, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(2, 0));
            for (int g = 0; g < gaps; g++) drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
            drive(1'b0, 1'b1, rnd ? 8'($urandom) : 8'(base + i), with_last && (i == n - 1));
        end
    endtask

    initial begin
        $display("[TB] starting");
        #1 i_rst_n = 1'b0;
        #1;
        check_output("rst_data", data_a, 96'h0);
        check_output("rst_busy", 96'(busy_a), 96'h0);
        idle(3);
        i_rst_n = 1'b1;
        idle(2);

        // Full frame, counting bytes, back to back.
        words_a.delete(); words_b.delete();
        apply_stimulus(EXP_A * LANES, 0, 1'b0, 0, 1'b1);
        idle(4);
        check_output("full_count", 96'(words_a.size()), 96'd96);
        check_output("full_first", words_a.size() > 0 ? words_a[0] : '0, 96'h0B0A09080706050403020100);
        check_output("full_last", words_a.size() > 95 ? words_a[95] : '0, 96'h7F7E7D7C7B7A797877767574);
        check_output("full_err_a", 96'(err_a), 96'h0);
        check_output("full_err_b", 96'(err_b), 96'h1);
        ref_words = words_a;

        // Partial final word: 17 bytes 0x01..0x11.
        words_a.delete(); words_b.delete();
        apply_stimulus(17, 1, 1'b0, 0, 1'b1);
        idle(4);
        check_output("part_count", 96'(words_b.size()), 96'd2);
        check_output("part_w1", words_b.size() > 0 ? words_b[0] : '0, 96'h0C0B0A090807060504030201);
        check_output("part_w2", words_b.size() > 1 ? words_b[1] : '0, 96'h0000000000000011100F0E0D);
        check_output("part_err_b", 96'(err_b), 96'h0);
        check_output("part_err_a", 96'(err_a), 96'h1);

        // Five words against 96 expected, then a start clears the flag.
        apply_stimulus(5 * LANES, 9, 1'b0, 0, 1'b1);
        idle(4);
        check_output("mis_err_a", 96'(err_a), 96'h1);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        check_output("mis_clear", 96'(err_a), 96'h0);

        // Abort after 7 bytes (also aborts the frame opened above), then gapped full frame.
        apply_stimulus(7, 200, 1'b0, 0, 1'b0);
        words_a.delete();
        apply_stimulus(EXP_A * LANES, 0, 1'b0, 1, 1'b1);
        idle(4);
        check_output("gap_count", 96'(words_a.size()), 96'd96);
        for (int k = 0; k < 96; k++)
            check_output("gap_word", words_a.size() > k ? words_a[k] : '0, ref_words[k]);
        check_output("gap_err_a", 96'(err_a), 96'h0);

        // Random frames with random gaps; start+byte during END must be ignored.
        for (int f = 0; f < 6; f++) begin
            apply_stimulus(int'($urandom_range(40, 1)), 0, 1'b1, 2, 1'b1);
            drive(1'b1, 1'b1, 8'($urandom), 1'b1);
            idle(int'($urandom_range(3, 1)));
        end

        // Reset in the middle of a frame.
        apply_stimulus(30, 3, 1'b0, 0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check_output("mrst_data", data_a, 96'h0);
        check_output("mrst_valid", 96'(valid_a), 96'h0);
        check_output("mrst_busy", 96'(busy_a), 96'h0);
        idle(2);
        i_rst_n = 1'b1;
        idle(2);
        words_a.delete();
        apply_stimulus(25, 0, 1'b1, 2, 1'b1);
        idle(4);
        check_output("post_rst_count", 96'(words_a.size()), 96'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
